// File: rtl/xmem_arbiter_pkg.sv
// Shared definitions for the X/Y/P data-RAM arbiter: FSM state encoding,
// requester IDs and default bus widths.
package xmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    localparam int XMEM_DATAW_DEF    = 24;
    localparam int XMEM_ADDRW_DEF    = 16;
    localparam int XMEM_LOCK_MAX_DEF = 15;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/xmem_arb_pick.sv
// Winner selection for the two-requester RAM arbiter (purely combinational).
// Precedence: a held lock keeps its owner; a lock broken at its limit hands
// the grant to the other requester if it is waiting; otherwise the requester
// named by ptr wins a collision. The fixed-priority build simply ties ptr to
// the core port.
module xmem_arb_pick
    import xmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    input  logic hold_valid,
    input  logic break_valid,
    input  logic owner_id,
    output logic grant_id,
    output logic grant_valid
);

    logic other_req;

    assign other_req = (owner_id == REQ_CORE) ? req1 : req0;

    // Resolve the winner in precedence order: hold, forced release, pointer.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ_CORE;
        if (hold_valid) begin
            grant_id = owner_id;
        end else if (break_valid && other_req) begin
            grant_id = other_id(owner_id);
        end else if (ptr == REQ_HOST) begin
            grant_id = req1 ? REQ_HOST : REQ_CORE;
        end else begin
            grant_id = req0 ? REQ_CORE : REQ_HOST;
        end
    end

endmodule

// File: rtl/xmem_arbiter.sv
// Arbiter and sequencer for the single-port X/Y/P data RAM.
// Requester 0 is the core AGU port, requester 1 the host/DMA port. Each access
// takes IDLE/DONE -> ACC -> DONE, so back-to-back throughput is one access per
// two cycles. Optional build macro XMEM_ARB_ROUND_ROBIN_EN turns on two-way
// round-robin priority; without it requester 0 always wins a collision.
//
//   state | meaning
//   IDLE  | no access in flight
//   ACC   | one RAM access cycle (write or oe asserted)
//   DONE  | acknowledge cycle; burst continuation or re-arbitration
module xmem_arbiter
    import xmem_arbiter_pkg::*;
#(
    parameter int DATAW    = XMEM_DATAW_DEF,
    parameter int ADDRW    = XMEM_ADDRW_DEF,
    parameter int LOCK_MAX = XMEM_LOCK_MAX_DEF
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [ADDRW-1:0] addr0,
    input  logic [ADDRW-1:0] addr1,
    input  logic [DATAW-1:0] wdata0,
    input  logic [DATAW-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [DATAW-1:0] rdata,
    output logic             busy,
    output logic [ADDRW-1:0] AB,
    output logic             write,
    output logic             oe,
    inout  wire  [DATAW-1:0] DB
);

    localparam int CNTW = $clog2(LOCK_MAX + 1);

    arb_state_t       state_q, state_d;
    logic             cmd_id_q, cmd_id_d;
    logic             cmd_we_q, cmd_we_d;
    logic [ADDRW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATAW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATAW-1:0] rdata_q, rdata_d;
    logic [CNTW-1:0]  lock_cnt_q, lock_cnt_d;

    logic ptr;
    logic in_done;
    logic own_req;
    logic own_lock;
    logic limit_hit;
    logic hold_valid;
    logic break_valid;
    logic grant_id;
    logic grant_valid;

    // lock_cnt_q counts burst continuations; the access finishing in DONE is
    // number lock_cnt_q+1 of the tenure, so the limit bites after LOCK_MAX.
    assign in_done     = (state_q == DONE);
    assign own_req     = (cmd_id_q == REQ_HOST) ? req1 : req0;
    assign own_lock    = (cmd_id_q == REQ_HOST) ? lock1 : lock0;
    assign limit_hit   = (int'(lock_cnt_q) + 1) >= LOCK_MAX;
    assign hold_valid  = in_done & own_lock & own_req & ~limit_hit;
    assign break_valid = in_done & own_lock & own_req & limit_hit;

`ifdef XMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    // Every completed grant hands priority to the requester that lost.
    always_comb begin
        ptr_d = ptr_q;
        if (in_done) begin
            ptr_d = other_id(cmd_id_q);
        end
    end

    // Priority pointer register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            ptr_q <= REQ_CORE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = REQ_CORE;
`endif

    xmem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .ptr         (ptr),
        .hold_valid  (hold_valid),
        .break_valid (break_valid),
        .owner_id    (cmd_id_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Next-state, command latch, lock counter and read-data capture.
    always_comb begin
        state_d     = state_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        lock_cnt_d  = lock_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d     = ACC;
                    cmd_id_d    = grant_id;
                    cmd_we_d    = (grant_id == REQ_HOST) ? we1 : we0;
                    cmd_addr_d  = (grant_id == REQ_HOST) ? addr1 : addr0;
                    cmd_wdata_d = (grant_id == REQ_HOST) ? wdata1 : wdata0;
                    lock_cnt_d  = '0;
                end
            end
            ACC: begin
                state_d = DONE;
                if (!cmd_we_q) begin
                    rdata_d = DB;
                end
            end
            DONE: begin
                if (grant_valid) begin
                    state_d     = ACC;
                    cmd_id_d    = grant_id;
                    cmd_we_d    = (grant_id == REQ_HOST) ? we1 : we0;
                    cmd_addr_d  = (grant_id == REQ_HOST) ? addr1 : addr0;
                    cmd_wdata_d = (grant_id == REQ_HOST) ? wdata1 : wdata0;
                    lock_cnt_d  = hold_valid ? (lock_cnt_q + CNTW'(1)) : '0;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // State and command registers; reset aborts any access in flight.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_id_q    <= REQ_CORE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            lock_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    // write and oe are both qualified by ACC and split by cmd_we_q, so they
    // can never overlap, and DB is only driven while write is high.
    assign busy  = (state_q == ACC);
    assign write = busy & cmd_we_q;
    assign oe    = busy & ~cmd_we_q;
    assign AB    = cmd_addr_q;
    assign ack0  = in_done & (cmd_id_q == REQ_CORE);
    assign ack1  = in_done & (cmd_id_q == REQ_HOST);
    assign rdata = rdata_q;
    assign DB    = write ? cmd_wdata_q : {DATAW{1'bz}};

endmodule

// File: tb/tb_xmem_arbiter.sv
// Testbench for xmem_arbiter: behavioural RAM on AB/DB, a table of single
// accesses, plus directed sequences for collisions, lock bursts, lock limit,
// random traffic against a memory model, and reset during ACC.
`timescale 1ns/1ps
module tb_xmem_arbiter;
    import xmem_arbiter_pkg::*;

    localparam int DW = 24;
    localparam int AW = 16;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, write, oe;
    logic [DW-1:0] rdata;
    logic [AW-1:0] AB;
    wire  [DW-1:0] DB;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_rd;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 Clk = ~Clk;

    xmem_arbiter dut (
        .Clk    (Clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .lock0  (lock0),
        .lock1  (lock1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata  (rdata),
        .busy   (busy),
        .AB     (AB),
        .write  (write),
        .oe     (oe),
        .DB     (DB)
    );

    // RAM: uses the low address bits, drives DB on oe, captures on negedge.
    always_comb ram_rd = ram[AB[7:0]];
    assign DB = oe ? ram_rd : {DW{1'bz}};
    always @(negedge Clk) if (write) ram[AB[7:0]] <= DB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (!reset) chk("oe_write_excl", 32'(oe & write), 32'd0);
    end

    task automatic drive(input logic id, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        if (id == REQ_HOST) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
        end
    endtask

    task automatic single(input logic id, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] e, input logic ce);
        @(posedge Clk); #1;
        drive(id, 1'b1, w, a, d, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ab", 32'(AB), 32'(a));
        chk("acc_write", 32'(write), 32'(w));
        chk("acc_oe", 32'(oe), 32'(!w));
        chk("acc_noack", 32'(ack0 | ack1), 32'd0);
        @(negedge Clk);
        chk("ack_winner", 32'(id ? ack1 : ack0), 32'd1);
        chk("ack_other", 32'(id ? ack0 : ack1), 32'd0);
        chk("done_write_oe", 32'(write | oe), 32'd0);
        if (!w && ce) chk("rdata", 32'(rdata), 32'(e));
        drive(id, 1'b0, 1'b0, a, d, 1'b0);
    endtask

    task automatic collide(input logic f);
        logic [AW-1:0] a_f, a_o;
        logic [DW-1:0] d_f, d_o;
        a_f = f ? 16'h0034 : 16'h0012;
        a_o = f ? 16'h0012 : 16'h0034;
        d_f = f ? 24'h123456 : 24'hFFFFFF;
        d_o = f ? 24'hFFFFFF : 24'h123456;
        @(posedge Clk); #1;
        drive(REQ_CORE, 1'b1, 1'b0, 16'h0012, '0, 1'b0);
        drive(REQ_HOST, 1'b1, 1'b0, 16'h0034, '0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("col_first_ab", 32'(AB), 32'(a_f));
        @(negedge Clk);
        chk("col_first_ack", 32'({ack1, ack0}), f ? 32'd2 : 32'd1);
        chk("col_first_rdata", 32'(rdata), 32'(d_f));
        drive(f, 1'b0, 1'b0, a_f, '0, 1'b0);
        @(negedge Clk);
        chk("col_second_ab", 32'(AB), 32'(a_o));
        chk("col_gap_noack", 32'(ack0 | ack1), 32'd0);
        @(negedge Clk);
        chk("col_second_ack", 32'({ack1, ack0}), f ? 32'd1 : 32'd2);
        chk("col_second_rdata", 32'(rdata), 32'(d_o));
        drive(!f, 1'b0, 1'b0, a_o, '0, 1'b0);
    endtask

    logic [DW-1:0] model [8];
    logic          valid [8];
    int            n0;
    logic          got1;
    logic [DW-1:0] rd_host;

    initial begin
        vecs[0]  = '{REQ_CORE, 1'b1, 16'h0012, 24'hA5A5A5, 24'h0};
        vecs[1]  = '{REQ_CORE, 1'b0, 16'h0012, 24'h0,      24'hA5A5A5};
        vecs[2]  = '{REQ_HOST, 1'b1, 16'h0034, 24'h123456, 24'h0};
        vecs[3]  = '{REQ_HOST, 1'b0, 16'h0034, 24'h0,      24'h123456};
        vecs[4]  = '{REQ_CORE, 1'b0, 16'h0034, 24'h0,      24'h123456};
        vecs[5]  = '{REQ_HOST, 1'b1, 16'h0012, 24'hFFFFFF, 24'h0};
        vecs[6]  = '{REQ_CORE, 1'b0, 16'h0012, 24'h0,      24'hFFFFFF};
        vecs[7]  = '{REQ_CORE, 1'b1, 16'h0000, 24'h0A0A0A, 24'h0};
        vecs[8]  = '{REQ_HOST, 1'b1, 16'h0001, 24'h0B0B0B, 24'h0};
        vecs[9]  = '{REQ_CORE, 1'b1, 16'h0002, 24'h0C0C0C, 24'h0};
        vecs[10] = '{REQ_CORE, 1'b1, 16'h12FF, 24'h000001, 24'h0};
        vecs[11] = '{REQ_HOST, 1'b0, 16'h12FF, 24'h0,      24'h000001};
        for (int i = 0; i < 8; i++) valid[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write_oe", 32'({write, oe}), 32'd0);
        chk("rst_ab", 32'(AB), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        @(posedge Clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            single(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1);

        // Collisions; a core-only access in between moves the round-robin pointer to the host
        collide(REQ_CORE);
        single(REQ_CORE, 1'b0, 16'h0012, '0, 24'hFFFFFF, 1'b1);
`ifdef XMEM_ARB_ROUND_ROBIN_EN
        collide(REQ_HOST);
`else
        collide(REQ_CORE);
`endif

        // Lock burst: three host reads run before the waiting core request
        @(posedge Clk); #1;
        drive(REQ_HOST, 1'b1, 1'b0, 16'h0000, '0, 1'b1);
        @(posedge Clk); #1;
        drive(REQ_CORE, 1'b1, 1'b0, 16'h0012, '0, 1'b0);
        @(negedge Clk);
        chk("burst_ab0", 32'(AB), 32'h0000);
        @(negedge Clk);
        chk("burst_ack_a", 32'({ack1, ack0}), 32'd2);
        chk("burst_rd_a", 32'(rdata), 32'h0A0A0A);
        addr1 = 16'h0001;
        @(negedge Clk);
        chk("burst_ab1", 32'(AB), 32'h0001);
        @(negedge Clk);
        chk("burst_ack_b", 32'({ack1, ack0}), 32'd2);
        chk("burst_rd_b", 32'(rdata), 32'h0B0B0B);
        addr1 = 16'h0002;
        @(negedge Clk);
        chk("burst_ab2", 32'(AB), 32'h0002);
        lock1 = 1'b0;
        @(negedge Clk);
        chk("burst_ack_c", 32'({ack1, ack0}), 32'd2);
        chk("burst_rd_c", 32'(rdata), 32'h0C0C0C);
        req1 = 1'b0;
        @(negedge Clk);
        chk("burst_core_ab", 32'(AB), 32'h0012);
        @(negedge Clk);
        chk("burst_core_ack", 32'({ack1, ack0}), 32'd1);
        chk("burst_core_rd", 32'(rdata), 32'hFFFFFF);
        req0 = 1'b0;

        // Lock limit: core holds lock0, host waits; host must win after 15 core accesses
        @(posedge Clk); #1;
        drive(REQ_CORE, 1'b1, 1'b0, 16'h0002, '0, 1'b1);
        @(posedge Clk); #1;
        drive(REQ_HOST, 1'b1, 1'b0, 16'h0001, '0, 1'b0);
        n0 = 0;
        got1 = 1'b0;
        rd_host = '0;
        for (int c = 0; c < 80 && !got1; c++) begin
            @(negedge Clk);
            if (ack0) n0++;
            if (ack1) begin
                got1 = 1'b1;
                rd_host = rdata;
            end
        end
        chk("lock_limit_host_served", 32'(got1), 32'd1);
        chk("lock_limit_core_count", 32'(n0), 32'd15);
        chk("lock_limit_host_rdata", 32'(rd_host), 32'h0B0B0B);
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge Clk);

        // Random traffic from both ports checked against a memory model
        for (int i = 0; i < 30; i++) begin
            logic          id, w;
            int            ix;
            logic [DW-1:0] d;
            id = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ix = int'($urandom_range(0, 7));
            d  = DW'($urandom);
            single(id, w, 16'(16'h0040 + ix), d, model[ix], valid[ix]);
            if (w) begin
                model[ix] = d;
                valid[ix] = 1'b1;
            end
        end

        // Reset during the ACC cycle of a read aborts it without an ack
        @(posedge Clk); #1;
        drive(REQ_CORE, 1'b1, 1'b0, 16'h0012, '0, 1'b0);
        @(posedge Clk); #1;
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge Clk);
        chk("rstacc_in_acc", 32'(oe), 32'd1);
        @(posedge Clk); #1;
        reset = 1'b0;
        @(negedge Clk);
        chk("rstacc_ack", 32'({ack1, ack0}), 32'd0);
        chk("rstacc_busy", 32'(busy), 32'd0);
        chk("rstacc_write_oe", 32'({write, oe}), 32'd0);
        chk("rstacc_ab", 32'(AB), 32'd0);
        chk("rstacc_rdata", 32'(rdata), 32'd0);
        chk("rstacc_state", 32'(dut.state_q), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
